// File: rtl/morse_symbol_controller.sv
// Morse symbol controller: groups dot/line strobes into characters
// of up to four symbols, ended by a quiet gap, with a ready/valid output.
module morse_symbol_controller #(
    parameter int GAP_CYCLES  = 8,
    parameter int MAX_SYMBOLS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ld_dot,
    input  logic       ld_line,
    input  logic       char_ready,
    output logic       char_valid,
    output logic [3:0] char_pattern,
    output logic [2:0] char_length,
    output logic       busy,
    output logic       err_pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISCARD,
        S_OUTPUT
    } state_t;

    localparam logic [7:0] GAP_END  = 8'(GAP_CYCLES - 2);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [2:0] LEN_MAX  = 3'(MAX_SYMBOLS);

    state_t     state_q;
    logic [7:0] gap_q;
    logic [7:0] gap_d;
    logic [3:0] pat_q;
    logic [2:0] len_q;
    logic [3:0] cp_q;
    logic [2:0] cl_q;
    logic       valid_q;
    logic       busy_q;
    logic       err_q;

    logic sym;
    logic conflict;
    logic strobe;

    assign sym      = ld_dot ^ ld_line;
    assign conflict = ld_dot & ld_line;
    assign strobe   = ld_dot | ld_line;
    assign gap_d    = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            cp_q    <= '0;
            cl_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (sym) begin
                        pat_q   <= {3'b000, ld_line};
                        len_q   <= 3'd1;
                        gap_q   <= '0;
                        state_q <= S_COLLECT;
                        busy_q  <= 1'b1;
                    end else if (conflict) begin
                        err_q   <= 1'b1;
                        gap_q   <= '0;
                        state_q <= S_DISCARD;
                        busy_q  <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (conflict || (sym && len_q == LEN_MAX)) begin
                        err_q   <= 1'b1;
                        pat_q   <= '0;
                        len_q   <= '0;
                        gap_q   <= '0;
                        state_q <= S_DISCARD;
                    end else if (sym) begin
                        pat_q[len_q[1:0]] <= ld_line;
                        len_q <= len_q + 3'd1;
                        gap_q <= '0;
                    end else begin
                        gap_q <= gap_d;
                        // Registered valid lands exactly GAP_CYCLES after the last strobe
                        if (gap_q == GAP_END) begin
                            state_q <= S_OUTPUT;
                            valid_q <= 1'b1;
                            cp_q    <= pat_q;
                            cl_q    <= len_q;
                        end
                    end
                end
                S_DISCARD: begin
                    if (strobe) begin
                        gap_q <= '0;
                    end else if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_d;
                    end
                end
                S_OUTPUT: begin
                    if (strobe) begin
                        err_q <= 1'b1;
                    end
                    if (char_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        cp_q    <= '0;
                        cl_q    <= '0;
                        pat_q   <= '0;
                        len_q   <= '0;
                        gap_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign char_valid   = valid_q;
    assign char_pattern = cp_q;
    assign char_length  = cl_q;
    assign busy         = busy_q;
    assign err_pulse    = err_q;

endmodule

// File: tb/tb_morse_symbol_controller.sv
// Directed bench for morse_symbol_controller with a scoreboard
// of expected characters popped on each accepted handshake.
module tb_morse_symbol_controller;

    logic       clk;
    logic       reset;
    logic       ld_dot;
    logic       ld_line;
    logic       char_ready;
    logic       char_valid;
    logic [3:0] char_pattern;
    logic [2:0] char_length;
    logic       busy;
    logic       err_pulse;

    int tests;
    int fails;
    int vcnt;
    int v0;
    logic [6:0] sb[$];

    morse_symbol_controller #(.GAP_CYCLES(8)) dut (
        .clock       (clk),
        .reset       (reset),
        .ld_dot      (ld_dot),
        .ld_line     (ld_line),
        .char_ready  (char_ready),
        .char_valid  (char_valid),
        .char_pattern(char_pattern),
        .char_length (char_length),
        .busy        (busy),
        .err_pulse   (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic d, input logic l, input logic r);
        ld_dot     = d;
        ld_line    = l;
        char_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, r);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(char_valid), 32'd0);
        chk({tag, "_err"}, 32'(err_pulse), 32'd0);
    endtask

    // Scoreboard pop on accept, plus zero outputs whenever invalid
    always @(negedge clk) begin
        if (!reset) begin
            if (char_valid) vcnt++;
            if (char_valid && char_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 32'({char_pattern, char_length}), 32'h7f);
                end else begin
                    chk("sb_char", 32'({char_pattern, char_length}),
                        32'(sb.pop_front()));
                end
            end
            if (!char_valid) begin
                chk("zero_when_invalid", 32'({char_pattern, char_length}), 32'd0);
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        vcnt  = 0;
        reset = 1'b1;
        ld_dot = 1'b1;
        ld_line = 1'b1;
        char_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 1'b0);
        chk_idle("reset");
        chk("reset_pat", 32'(char_pattern), 32'd0);
        chk("reset_len", 32'(char_length), 32'd0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        chk_idle("post_reset");

        // dot at cycle 0, line at cycle 3, valid at cycle 11
        sb.push_back({4'b0010, 3'd2});
        cyc(1'b1, 1'b0, 1'b0);
        chk("c1_busy", 32'(busy), 32'd1);
        quiet(2, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        quiet(6, 1'b0);
        chk("c1_valid_early", 32'(char_valid), 32'd0);
        quiet(1, 1'b0);
        chk("c1_valid", 32'(char_valid), 32'd1);
        chk("c1_pat", 32'(char_pattern), 32'h2);
        chk("c1_len", 32'(char_length), 32'd2);
        cyc(1'b0, 1'b0, 1'b1);
        chk_idle("c1_after");
        cyc(1'b0, 1'b0, 1'b0);

        // five dots two cycles apart -> overflow discard
        v0 = vcnt;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("ov_err_low", 32'(err_pulse), 32'd0);
            quiet(1, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("ov_err", 32'(err_pulse), 32'd1);
        quiet(1, 1'b0);
        chk("ov_err_once", 32'(err_pulse), 32'd0);
        quiet(6, 1'b0);
        chk("ov_busy_hold", 32'(busy), 32'd1);
        quiet(1, 1'b0);
        chk_idle("ov_idle");
        chk("ov_novalid", 32'(vcnt - v0), 32'd0);

        // held character with dropped strobe
        sb.push_back({4'b0010, 3'd3});
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        quiet(7, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(i == 5, 1'b0, 1'b0);
            chk("hold_valid", 32'(char_valid), 32'd1);
            chk("hold_pat", 32'(char_pattern), 32'h2);
            chk("hold_len", 32'(char_length), 32'd3);
            chk("hold_err", 32'(err_pulse), 32'(i == 5));
        end
        cyc(1'b0, 1'b0, 1'b1);
        chk_idle("hold_after");

        // conflict in idle
        v0 = vcnt;
        cyc(1'b1, 1'b1, 1'b0);
        chk("cf_err", 32'(err_pulse), 32'd1);
        chk("cf_busy", 32'(busy), 32'd1);
        quiet(7, 1'b0);
        chk("cf_busy_hold", 32'(busy), 32'd1);
        quiet(1, 1'b0);
        chk_idle("cf_idle");

        // conflict in collect, then a strobe restarts the discard gap
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("cc_err", 32'(err_pulse), 32'd1);
        quiet(5, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("dc_err", 32'(err_pulse), 32'd0);
        quiet(7, 1'b0);
        chk("dc_busy_hold", 32'(busy), 32'd1);
        quiet(1, 1'b0);
        chk_idle("dc_idle");
        chk("cf_novalid", 32'(vcnt - v0), 32'd0);

        // reset mid-collect
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        chk_idle("rst_mid");
        sb.push_back({4'b0001, 3'd1});
        cyc(1'b0, 1'b1, 1'b0);
        quiet(7, 1'b0);
        chk("rst_valid", 32'(char_valid), 32'd1);
        chk("rst_pat", 32'(char_pattern), 32'h1);
        chk("rst_len", 32'(char_length), 32'd1);
        cyc(1'b0, 1'b0, 1'b1);
        chk_idle("rst_after");

        // four lines, ready already high when valid rises
        v0 = vcnt;
        sb.push_back({4'b1111, 3'd4});
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
        quiet(7, 1'b1);
        chk("l4_valid", 32'(char_valid), 32'd1);
        chk("l4_pat", 32'(char_pattern), 32'hf);
        chk("l4_len", 32'(char_length), 32'd4);
        quiet(1, 1'b1);
        chk_idle("l4_after");
        quiet(2, 1'b0);
        chk("l4_one_cycle", 32'(vcnt - v0), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
